// File: rtl/clock24_pkg.sv
// Shared types and limits for the 24-hour clock alarm logic.
// ALARM_SNOOZE_EN adds the SNOOZE state to alm_state_t.
package clock24_pkg;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_RINGING
`ifdef ALARM_SNOOZE_EN
        , ST_SNOOZE
`endif
    } alm_state_t;

    function automatic bcd_pair to_bcd(input int unsigned v);
        bcd_pair r;
        r.tens = 4'(v / 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/alm_bcd_inc.sv
// Two-digit BCD register that counts up on inc and wraps to 00 after LIMIT.
module alm_bcd_inc
    import clock24_pkg::*;
#(
    parameter int      LIMIT   = MIN_MAX,
    parameter bcd_pair RST_VAL = '0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    inc,
    output bcd_pair q
);

    localparam bcd_pair LIM = to_bcd(LIMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (inc) begin
            if (q == LIM)
                q <= '0;
            else if (q.ones == 4'd9)
                q <= '{tens: q.tens + 4'd1, ones: 4'd0};
            else
                q.ones <= q.ones + 4'd1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm-time setting, arm/disarm, ringing and auto-stop.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and its counter.
module alarm_ctrl
    import clock24_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int RST_HOUR   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en1hz,
    input  logic       sig2hz,
    input  logic       almkey,
    input  logic       select,
    input  logic       adjust,
    input  logic [1:0] hour10,
    input  logic [3:0] hour1,
    input  logic [2:0] min10,
    input  logic [3:0] min1,
    input  logic [2:0] sec10,
    input  logic [3:0] sec1,
    output logic [1:0] ahour10,
    output logic [3:0] ahour1,
    output logic [2:0] amin10,
    output logic [3:0] amin1,
    output logic       almsel,
    output logic       ahouron,
    output logic       aminon,
    output logic       armed,
    output logic       buzz
);

    if (RING_SEC < 1 || SNOOZE_SEC < 1) begin : g_param_check
        $error("alarm_ctrl: RING_SEC and SNOOZE_SEC must be at least 1");
    end

    localparam int RING_W = $clog2(RING_SEC + 1);

    alm_state_t        state, state_n;
    logic              armed_n;
    logic              match, match_q, trigger;
    logic              k_alm, k_sel, k_adj;
    logic              hour_inc, min_inc;
    logic              ring_clr, ring_inc;
    logic [RING_W-1:0] ring_cnt;
    bcd_pair           ahour, amin;

    // Only the highest-priority key of a simultaneous group acts.
    assign k_alm = almkey;
    assign k_sel = select & ~almkey;
    assign k_adj = adjust & ~almkey & ~select;

    alm_bcd_inc #(.LIMIT(HOUR_MAX), .RST_VAL(to_bcd(RST_HOUR))) u_hour (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (hour_inc),
        .q    (ahour)
    );

    alm_bcd_inc #(.LIMIT(MIN_MAX), .RST_VAL('0)) u_min (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (min_inc),
        .q    (amin)
    );

    assign ahour10 = ahour.tens[1:0];
    assign ahour1  = ahour.ones;
    assign amin10  = amin.tens[2:0];
    assign amin1   = amin.ones;

    assign match = armed
                 & ({2'b00, hour10} == ahour.tens) & (hour1 == ahour.ones)
                 & ({1'b0, min10} == amin.tens) & (min1 == amin.ones)
                 & (sec10 == 3'd0) & (sec1 == 4'd0);
    assign trigger = match & ~match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state   <= state_n;
            armed   <= armed_n;
            match_q <= match;
        end
    end

    // Counters saturate at their terminal value; the FSM leaves the state there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ring_cnt <= '0;
        else if (ring_clr)
            ring_cnt <= '0;
        else if (ring_inc)
            ring_cnt <= ring_cnt + RING_W'(1);
    end

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);

    logic             snz_clr, snz_inc;
    logic [SNZ_W-1:0] snz_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snz_cnt <= '0;
        else if (snz_clr)
            snz_cnt <= '0;
        else if (snz_inc)
            snz_cnt <= snz_cnt + SNZ_W'(1);
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        armed_n  = armed;
        hour_inc = 1'b0;
        min_inc  = 1'b0;
        ring_clr = 1'b0;
        ring_inc = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_clr  = 1'b0;
        snz_inc  = 1'b0;
`endif
        almsel   = 1'b0;
        ahouron  = 1'b1;
        aminon   = 1'b1;
        buzz     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (k_alm)
                    state_n = ST_SET_HOUR;
                else if (k_adj)
                    armed_n = ~armed;
                else if (trigger) begin
                    state_n  = ST_RINGING;
                    ring_clr = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                almsel  = 1'b1;
                ahouron = sig2hz;
                if (k_alm)
                    state_n = ST_IDLE;
                else if (k_sel)
                    state_n = ST_SET_MIN;
                else if (k_adj)
                    hour_inc = 1'b1;
            end
            ST_SET_MIN: begin
                almsel = 1'b1;
                aminon = sig2hz;
                if (k_alm)
                    state_n = ST_IDLE;
                else if (k_sel) begin
                    state_n = ST_IDLE;
                    armed_n = 1'b1;
                end else if (k_adj)
                    min_inc = 1'b1;
            end
            ST_RINGING: begin
                buzz = sig2hz;
                if (k_alm || k_adj)
                    state_n = ST_IDLE;
                else if (k_sel) begin
`ifdef ALARM_SNOOZE_EN
                    state_n = ST_SNOOZE;
                    snz_clr = 1'b1;
`else
                    state_n = ST_IDLE;
`endif
                end else if (ring_cnt == RING_W'(RING_SEC))
                    state_n = ST_IDLE;
                else if (en1hz)
                    ring_inc = 1'b1;
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (k_alm || k_adj)
                    state_n = ST_IDLE;
                else if (snz_cnt == SNZ_W'(SNOOZE_SEC)) begin
                    state_n  = ST_RINGING;
                    ring_clr = 1'b1;
                end else if (en1hz)
                    snz_inc = 1'b1;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller for the 24-hour clock.
- Holds a BCD alarm time (HH:MM) and sequences alarm-set, armed/disarmed, ringing and snooze.
- Compares the running time from the hour/min/sec counters and drives the buzzer.
- Sits beside the existing mode-state controller. The top level uses its outputs to mux alarm digits onto the 7-seg decoders while setting.

Parameters:
- RING_SEC, 60, en1hz pulses of ringing before auto-stop (≥1).
- SNOOZE_SEC, 300, en1hz pulses in snooze before re-ring (≥1).
- RST_HOUR, 6, reset alarm hour, binary 0–23, stored as BCD.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- en1hz  in  1  one-CLK pulse per second.
- sig2hz  in  1  2 Hz blink/beep square wave.
- almkey  in  1  debounced one-CLK pulse: alarm-mode key.
- select  in  1  debounced one-CLK pulse.
- adjust  in  1  debounced one-CLK pulse.
- hour10 / hour1  in  2 / 4  current hour, BCD.
- min10 / min1  in  3 / 4  current minute, BCD.
- sec10 / sec1  in  3 / 4  current second, BCD.
- ahour10 / ahour1  out  2 / 4  alarm hour, BCD.
- amin10 / amin1  out  3 / 4  alarm minute, BCD.
- almsel  out  1  1 = display alarm digits instead of time.
- ahouron / aminon  out  1  digit-group enables (blink while setting).
- armed  out  1  alarm armed LED.
- buzz  out  1  buzzer drive.

Behaviour:
- All state updates on posedge CLK. RST low clears asynchronously:
  - state=IDLE, armed=0, alarm=RST_HOUR:00, counters=0, match_q=0.
  - Outputs: almsel=0, buzz=0, ahouron=aminon=1.
- States: IDLE, SET_HOUR, SET_MIN, RINGING, SNOOZE (SNOOZE only if the optional feature is compiled in).
- Same-cycle key priority: almkey > select > adjust. Only the highest-priority key acts.
- IDLE:
  - almkey -> SET_HOUR.
  - adjust toggles armed.
  - select ignored.
- SET_HOUR:
  - adjust increments alarm hour 00..23, wraps 23->00 (hour1 9->0 carries into hour10).
  - select -> SET_MIN.
  - almkey -> IDLE; edits kept, armed unchanged.
- SET_MIN:
  - adjust increments alarm minute 00..59, wraps 59->00 with no hour carry.
  - select -> IDLE and sets armed=1.
  - almkey -> IDLE, armed unchanged.
- Set-state outputs:
  - almsel=1 in SET_HOUR/SET_MIN, else 0.
  - SET_HOUR: ahouron=sig2hz, aminon=1.
  - SET_MIN: ahouron=1, aminon=sig2hz.
  - All other states: both 1.
- Match and trigger:
  - match = armed & (hour==alarm hour) & (min==alarm min) & (sec==00). match_q is its registered copy.
  - Trigger = match & ~match_q, acted on only in IDLE: IDLE -> RINGING next cycle, ring counter cleared.
  - A trigger arising in any other state is dropped. It does not re-fire later in the same second.
- RINGING:
  - buzz = sig2hz, i.e. buzz goes high within 1 CLK of entry when sig2hz=1.
  - Ring counter increments on en1hz; at RING_SEC -> IDLE, armed stays 1.
  - adjust or almkey -> IDLE (stop).
  - select -> SNOOZE, snooze counter cleared.
- SNOOZE:
  - buzz=0. Counter increments on en1hz; at SNOOZE_SEC -> RINGING with ring counter cleared.
  - adjust or almkey -> IDLE.
- Counters are sized $clog2(param+1) and never wrap.
- Setting the alarm to the current time while in a set state does not ring: the trigger is ignored outside IDLE and match_q tracks continuously.
- Disarming (adjust in IDLE) while match is high prevents any ring.
- buzz is 0 in every state except RINGING.

Optional Feature:
- ALARM_SNOOZE_EN defined: SNOOZE state and counter exist as above.
- Undefined:
  - No SNOOZE state or snooze counter.
  - select in RINGING behaves as stop (-> IDLE).
  - SNOOZE_SEC is unused.

Decomposition:
- Package clock24_pkg holds:
  - state enum alm_state_t.
  - BCD limit constants HOUR_MAX=23, MIN_MAX=59.
  - a bcd_pair typedef.
- One sub-module alm_bcd_inc: a BCD digit-pair register with inc and a wrap limit.
  - Instanced twice: hour (limit 23) and minute (limit 59).
  - Reset value set by parameter.

Test Plan:
- Reset mid-RINGING (RST low for 1 CLK) -> state IDLE, buzz=0, armed=0, alarm reads 06:00.
- almkey, adjust×19, select, adjust×61, select -> alarm 01:01 (hour 06+19 wraps to 01; min 61 wraps to 01), armed=1, almsel back to 0.
- Alarm 07:30 armed; time steps 07:29:59->07:30:00 -> RINGING, buzz follows sig2hz; after 60 en1hz pulses -> IDLE, buzz=0.
- RINGING then select -> buzz=0 for 300 en1hz, then RINGING again. Without ALARM_SNOOZE_EN: select -> IDLE at once.
- almkey and adjust pulsed in the same cycle in IDLE -> SET_HOUR entered, armed unchanged.
- Disarm (adjust) at 07:30:00 with match high -> no ring. Re-arm at 07:30:00 with sec still 00 -> rings; same second in a set state -> no ring.
